// File: rtl/if_prefetch_queue.sv
// Instruction prefetch front-end: issues in-order IMEM fetches ahead of
// decode and buffers returned instructions with their PC in a small queue.
// A redirect flushes the queue and discards every response still in flight.
module if_prefetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter int                    MAX_OUT    = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   boot_add,
  input  logic                    redirect,
  input  logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic                    imem_req,
  output logic [DATA_WIDTH-1:0]   imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_instr,
  output logic [DATA_WIDTH-1:0]   out_pc,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   fetch_pc, resp_pc, addr_hold;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           outstanding, discard;
  logic [DATA_WIDTH-1:0]   mem_instr [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_pc    [DEPTH];
  logic                    flush, grant, rsp, push, pop;
  logic [CW:0]             credit_used;

  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign grant       = imem_req & imem_gnt;
  assign rsp         = imem_rvalid & (outstanding != '0);
  assign push        = (state == RUN) & ~flush & rsp & (discard == '0);
  assign pop         = ~flush & out_valid & out_ready;

  // Next-state and request generation; a request is only raised when the
  // queue has room for every response already owed plus this one.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    flush      = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        flush    = redirect;
        imem_req = ~redirect && (outstanding < MAX_OUT_W) && (credit_used < DEPTH_W);
      end
      default: state_next = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // Fetch/response PCs, pointers, occupancy and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= '0;
      resp_pc     <= '0;
      addr_hold   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (imem_req) addr_hold <= fetch_pc;
      if (state == BOOT) begin
        fetch_pc <= boot_add;
        resp_pc  <= boot_add;
      end else if (flush) begin
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        discard     <= outstanding - CW'(rsp);
        outstanding <= outstanding - CW'(rsp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
        outstanding <= outstanding + CW'(grant) - CW'(rsp);
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + DATA_WIDTH'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= resp_pc;
    end
  end

  assign imem_addr = imem_req ? fetch_pc : addr_hold;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem_instr[rd_ptr] : NOP_INSTR;
  assign out_pc    = out_valid ? mem_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: an in-order IMEM with variable
// latency feeds the design while a queue-based reference model predicts
// requests, addresses and the delivered instruction stream.
module tb_if_prefetch_queue;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUT   = 2;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] boot_add;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int rdy; } pend_t;

  // Reference model state
  bit          mBooted;
  logic [31:0] mFetch, mResp, mAddr;
  int          mOut, mDisc;
  ent_t        mQ[$];
  // IMEM environment state
  pend_t       pend[$];
  int          cyc, latMin, latMax;
  int          errCount, checkCount;

  if_prefetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .boot_add(boot_add), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction word the IMEM returns for a given address.
  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBooted = 0; mFetch = '0; mResp = '0; mAddr = '0;
    mOut = 0; mDisc = 0;
    mQ.delete();
    pend.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"},   32'(imem_req), 32'h0);
    checkOutput({tag, "_addr"},  imem_addr, 32'h0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, "_instr"}, out_instr, NOP_INSTR);
    checkOutput({tag, "_pc"},    out_pc, 32'h0);
    checkOutput({tag, "_count"}, 32'(count), 32'h0);
  endtask

  // One clock cycle: drive inputs, check outputs, then advance model and IMEM.
  task automatic applyStimulus(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          expReq, rsp, dutReq;
    logic [31:0] expAddr, dutAddr;
    ent_t        e;
    @(negedge clk);
    imem_gnt = gnt; out_ready = rdy; redirect = redir; redirect_pc = rpc;
    if (pend.size() > 0 && pend[0].rdy <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = instrOf(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    expReq  = mBooted && !redir && (mOut < MAX_OUT) && (mQ.size() + mOut < DEPTH);
    expAddr = expReq ? mFetch : mAddr;
    checkOutput("imem_req",  32'(imem_req), 32'(expReq));
    checkOutput("imem_addr", imem_addr, expAddr);
    checkOutput("out_valid", 32'(out_valid), 32'(mQ.size() != 0));
    if (mQ.size() != 0) begin
      checkOutput("out_pc",    out_pc, mQ[0].pc);
      checkOutput("out_instr", out_instr, mQ[0].instr);
    end else begin
      checkOutput("out_pc",    out_pc, 32'h0);
      checkOutput("out_instr", out_instr, NOP_INSTR);
    end
    checkOutput("count", 32'(count), 32'(mQ.size()));
    dutReq = imem_req; dutAddr = imem_addr;
    @(posedge clk);
    rsp = imem_rvalid && (mOut > 0);
    if (!mBooted) begin
      mBooted = 1; mFetch = boot_add; mResp = boot_add;
    end else if (redir) begin
      mDisc = mOut - int'(rsp);
      mOut  = mOut - int'(rsp);
      mQ.delete();
      mFetch = rpc; mResp = rpc;
    end else begin
      if (mQ.size() != 0 && rdy) void'(mQ.pop_front());
      if (rsp) begin
        if (mDisc > 0) mDisc--;
        else begin
          e.pc = mResp; e.instr = imem_rdata;
          mQ.push_back(e);
          mResp = mResp + 32'd4;
        end
      end
      if (expReq && gnt) begin
        mOut++;
        mFetch = mFetch + 32'd4;
      end
      if (rsp) mOut--;
    end
    mAddr = expAddr;
    if (imem_rvalid) void'(pend.pop_front());
    if (dutReq && gnt) pend.push_back('{addr: dutAddr, rdy: cyc + int'($urandom_range(latMax, latMin))});
    cyc++;
  endtask

  initial begin
    errCount = 0; checkCount = 0; cyc = 0;
    latMin = 1; latMax = 1;
    rst_n = 1'b0; boot_add = 32'h100; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Boot, single-cycle latency, decode always ready
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 32'h0);
    // Decode stalled until the queue fills, then drained
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 32'h0);
    // Longer latency with requests in flight, then redirect
    latMin = 3; latMax = 3;
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 32'h200);
    for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0, 32'h0);
    // Redirect coinciding with a response and a ready decode
    latMin = 1; latMax = 1;
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 32'h300);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 32'h0);
    // Grant withheld for five cycles
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 32'h0);
    // Address wrap past the top of the address space
    applyStimulus(1, 1, 1, 32'hFFFFFFF8);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 32'h0);

    // Randomized traffic
    latMin = 1; latMax = 4;
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom & 32'hFFFFFFFC);

    // Asynchronous reset in the middle of traffic
    @(negedge clk); #2 rst_n = 1'b0;
    #1 checkResetOutputs("midreset");
    imem_rvalid = 1'b0; redirect = 1'b0;
    modelReset();
    boot_add = 32'h4000;
    @(posedge clk); #1 rst_n = 1'b1;
    // Redirect during boot must be ignored
    applyStimulus(1, 1, 1, 32'h8000);
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom & 32'hFFFFFFFC);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
